// File: rtl/sw_out_allocator_pkg.sv
// Shared definitions for the output-port allocator, crossbar and OVC status blocks.
package sw_out_allocator_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_t;

  // Minimum of 1 so a degenerate single-requester port still has a select bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // A port never sends to itself, so each output sees one fewer requester than ports.
  function automatic int req_num(input int port_num);
    return port_num - 1;
  endfunction

endpackage

// File: rtl/sw_out_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-two N correct.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end

endmodule

// File: rtl/sw_out_allocator.sv
// Output-port allocator: round-robin on packet headers, grant held to the tail flit.
module sw_out_allocator
  import sw_out_allocator_pkg::*;
#(
  parameter  int PORT_NUM        = 5,
  parameter  int VC_NUM_PER_PORT = 4,
  parameter  int SEL_WIDTH       = clog2(PORT_NUM - 1),
  localparam int REQ_NUM         = req_num(PORT_NUM)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [REQ_NUM-1:0]                 req,
  input  logic [REQ_NUM-1:0]                 req_tail,
  input  logic [REQ_NUM*VC_NUM_PER_PORT-1:0] req_vc,
  input  logic [VC_NUM_PER_PORT-1:0]         credit_avail,
  output logic [REQ_NUM-1:0]                 grant,
  output logic                               grant_valid,
  output logic [SEL_WIDTH-1:0]               sel,
  output logic                               locked
);

  alloc_state_t         state;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] owner;

  logic [REQ_NUM-1:0]   eligible;
  logic [REQ_NUM-1:0]   arb_grant;
  logic [SEL_WIDTH-1:0] arb_idx;
  logic                 arb_any;
  logic [SEL_WIDTH-1:0] ptr_next;

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_elig
    assign eligible[i] = req[i] & |(req_vc[i*VC_NUM_PER_PORT +: VC_NUM_PER_PORT] & credit_avail);
  end

  rr_arbiter #(.N(REQ_NUM), .W(SEL_WIDTH)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign ptr_next = (arb_idx == SEL_WIDTH'(REQ_NUM - 1)) ? '0 : arb_idx + 1'b1;

  // Zero-cycle grant; while locked only the owner may move a flit.
  always_comb begin
    grant = '0;
    sel   = '0;
    if (reset) begin
      if (state == IDLE) begin
        grant = arb_grant;
        sel   = arb_idx;
      end else if (eligible[owner]) begin
        grant[owner] = 1'b1;
        sel          = owner;
      end
    end
  end

  assign grant_valid = |grant;
  assign locked      = reset && (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            rr_ptr <= ptr_next;
            if (!req_tail[arb_idx]) begin
              state <= LOCKED;
              owner <= arb_idx;
            end
          end
        end
        LOCKED: begin
          if (eligible[owner] && req_tail[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
